// File: rtl/aes_pkg.sv
// Shared definitions for the subByte arbitration slice.
//  - default datapath widths for the round state and key-schedule word
//  - owner encoding carried in the issue tag
//  - tag layout used by the in-flight tag pipe
package aes_pkg;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int KEY_WIDTH_DEF  = 32;

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_KS = 1'b1
  } owner_e;

  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;
endpackage

// File: rtl/sub_byte_arbiter_rr_arb2.sv
// rr_arb2: two-way grant logic for the ST and KS requesters plus the
// last_grant register.
//  clk, rst      clock, asynchronous active-low reset
//  st_valid      ST request valid
//  ks_valid      KS request valid
//  st_grant      ST wins this cycle (doubles as ST ready / accept)
//  ks_grant      KS wins this cycle (doubles as KS ready / accept)
//  winner        owner of this cycle's grant (OWN_ST when nothing granted)
// PRIORITY_MODE 0 alternates under contention, 1 always favours ST.
module rr_arb2
  import aes_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic st_valid,
  input  logic ks_valid,
  output logic st_grant,
  output logic ks_grant,
  output logic winner
);

  owner_e last_grant_q, last_grant_d;

  always_comb begin
    st_grant     = 1'b0;
    ks_grant     = 1'b0;
    last_grant_d = last_grant_q;
    if (st_valid && ks_valid) begin
      // Contention: the requester that did not win last time goes next.
      if (PRIORITY_MODE == 1 || last_grant_q == OWN_KS) st_grant = 1'b1;
      else                                              ks_grant = 1'b1;
    end else begin
      st_grant = st_valid;
      ks_grant = ks_valid;
    end
    // A grant is always an accept, so last_grant moves only on accepts.
    if (st_grant)      last_grant_d = OWN_ST;
    else if (ks_grant) last_grant_d = OWN_KS;
    winner = ks_grant;
  end

  // Reset to KS so ST wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= OWN_KS;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/sub_byte_arbiter.sv
// sub_byte_arbiter: shares one subByte instance between the round state
// path (ST, full state) and the key schedule (KS, one SubWord).
//  clk, rst                   clock, asynchronous active-low reset
//  st_req_valid/ready/data    ST request handshake and state
//  ks_req_valid/ready/data    KS request handshake and word
//  sb_valid_in, sb_data_in    issue to subByte
//  sb_valid_out, sb_data_out  result from subByte
//  st_rsp_valid/data          ST result, one-cycle pulse, data held between
//  ks_rsp_valid/data          KS result, one-cycle pulse, data held between
//  err                        sticky tag/result disagreement
// Each issue pushes {vld, owner} into a LATENCY-deep tag pipe that tracks
// the subByte pipeline; the head tag routes the returning result.
module sub_byte_arbiter
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int KEY_WIDTH     = KEY_WIDTH_DEF,
  parameter int LATENCY       = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_req_valid,
  output logic                  st_req_ready,
  input  logic [DATA_WIDTH-1:0] st_req_data,
  input  logic                  ks_req_valid,
  output logic                  ks_req_ready,
  input  logic [KEY_WIDTH-1:0]  ks_req_data,
  output logic                  sb_valid_in,
  output logic [DATA_WIDTH-1:0] sb_data_in,
  input  logic                  sb_valid_out,
  input  logic [DATA_WIDTH-1:0] sb_data_out,
  output logic                  st_rsp_valid,
  output logic [DATA_WIDTH-1:0] st_rsp_data,
  output logic                  ks_rsp_valid,
  output logic [KEY_WIDTH-1:0]  ks_rsp_data,
  output logic                  err
);

  logic st_grant, ks_grant, winner, accept;

  rr_arb2 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_req_valid),
    .ks_valid (ks_req_valid),
    .st_grant (st_grant),
    .ks_grant (ks_grant),
    .winner   (winner)
  );

  assign st_req_ready = st_grant;
  assign ks_req_ready = ks_grant;
  assign accept       = st_grant | ks_grant;
  assign sb_valid_in  = accept;

  // Idle cycles drive zero so the subByte inputs do not toggle.
  always_comb begin
    sb_data_in = '0;
    if (st_grant)      sb_data_in = st_req_data;
    else if (ks_grant) sb_data_in = DATA_WIDTH'(ks_req_data);
  end

  // Tag pipe: shifts every cycle, head lines up with sb_valid_out.
  tag_t [LATENCY-1:0] tag_q, tag_d;
  tag_t               head;

  always_comb begin
    tag_d[0] = '{vld: accept, own: winner};
    for (int i = 1; i < LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  assign head = tag_q[LATENCY-1];

  logic                  st_rsp_valid_q, st_rsp_valid_d;
  logic                  ks_rsp_valid_q, ks_rsp_valid_d;
  logic [DATA_WIDTH-1:0] st_rsp_data_q, st_rsp_data_d;
  logic [KEY_WIDTH-1:0]  ks_rsp_data_q, ks_rsp_data_d;
  logic                  err_q, err_d;

  always_comb begin
    st_rsp_valid_d = sb_valid_out && head.vld && (head.own == OWN_ST);
    ks_rsp_valid_d = sb_valid_out && head.vld && (head.own == OWN_KS);
    st_rsp_data_d  = st_rsp_valid_d ? sb_data_out : st_rsp_data_q;
    ks_rsp_data_d  = ks_rsp_valid_d ? sb_data_out[KEY_WIDTH-1:0] : ks_rsp_data_q;
    // Either a result with no tag or a tag with no result is a lost sync.
    err_d          = err_q | (sb_valid_out ^ head.vld);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q          <= '0;
      st_rsp_valid_q <= 1'b0;
      ks_rsp_valid_q <= 1'b0;
      st_rsp_data_q  <= '0;
      ks_rsp_data_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      tag_q          <= tag_d;
      st_rsp_valid_q <= st_rsp_valid_d;
      ks_rsp_valid_q <= ks_rsp_valid_d;
      st_rsp_data_q  <= st_rsp_data_d;
      ks_rsp_data_q  <= ks_rsp_data_d;
      err_q          <= err_d;
    end
  end

  assign st_rsp_valid = st_rsp_valid_q;
  assign ks_rsp_valid = ks_rsp_valid_q;
  assign st_rsp_data  = st_rsp_data_q;
  assign ks_rsp_data  = ks_rsp_data_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sub_byte_arbiter.sv
// Bench for sub_byte_arbiter: instance 0 round-robin, instance 1 fixed
// priority, both fed the same requests, each with its own 1-cycle subByte
// model. A per-instance scoreboard queue holds {owner, data, due cycle}.
module tb_sub_byte_arbiter;
  localparam int DW = 128;
  localparam int KW = 32;

  localparam logic [127:0] SB_ROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SB_ROW[b[7:4]];
    return row[8*(15-int'(b[3:0])) +: 8];
  endfunction

  function automatic logic [DW-1:0] sub_word(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < DW/8; i++) r[8*i +: 8] = sbox(x[8*i +: 8]);
    return r;
  endfunction

  typedef struct {
    logic          own;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic st_v = 1'b0, ks_v = 1'b0, inj = 1'b0;
  logic [DW-1:0] st_d = '0;
  logic [KW-1:0] ks_d = '0;
  int cyc = 0;
  int total = 0, bad = 0;

  logic [1:0] st_rdy, ks_rdy, sb_vin, sb_vout, st_rv, ks_rv, err;
  logic [DW-1:0] sb_din [2];
  logic [DW-1:0] sb_dout [2];
  logic [DW-1:0] st_rd [2];
  logic [KW-1:0] ks_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    exp_t q[$];
    int st_cnt = 0, ks_cnt = 0;
    logic mvo;
    logic [DW-1:0] mdo;

    sub_byte_arbiter #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .LATENCY(1), .PRIORITY_MODE(g)) u_dut (
      .clk(clk), .rst(rst),
      .st_req_valid(st_v), .st_req_ready(st_rdy[g]), .st_req_data(st_d),
      .ks_req_valid(ks_v), .ks_req_ready(ks_rdy[g]), .ks_req_data(ks_d),
      .sb_valid_in(sb_vin[g]), .sb_data_in(sb_din[g]),
      .sb_valid_out(sb_vout[g]), .sb_data_out(sb_dout[g]),
      .st_rsp_valid(st_rv[g]), .st_rsp_data(st_rd[g]),
      .ks_rsp_valid(ks_rv[g]), .ks_rsp_data(ks_rd[g]),
      .err(err[g]));

    // subByte stand-in: one register stage, shares the reset
    always @(posedge clk or negedge rst) begin
      if (!rst) begin mvo <= 1'b0; mdo <= '0; end
      else begin mvo <= sb_vin[g]; mdo <= sub_word(sb_din[g]); end
    end
    assign sb_vout[g] = mvo | inj;
    assign sb_dout[g] = mdo;

    always @(negedge clk) begin
      exp_t e;
      if (!rst) q.delete();
      else begin
        if (st_rdy[g] && ks_rdy[g]) begin
          total++; bad++; $display("FAIL both_ready dut%0d cyc=%0d", g, cyc);
        end
        if ((st_rdy[g] && !st_v) || (ks_rdy[g] && !ks_v)) begin
          total++; bad++; $display("FAIL ready_without_valid dut%0d cyc=%0d", g, cyc);
        end
        if (!sb_vin[g] && sb_din[g] !== '0) begin
          total++; bad++; $display("FAIL idle_data dut%0d got=%h want=0", g, sb_din[g]);
        end
        if (st_v && st_rdy[g]) begin
          total++;
          if (sb_vin[g] !== 1'b1 || sb_din[g] !== st_d) begin
            bad++; $display("FAIL st_issue dut%0d got=%b/%h want=1/%h", g, sb_vin[g], sb_din[g], st_d);
          end
          q.push_back('{own: 1'b0, data: sub_word(st_d), due: cyc + 2});
        end else if (ks_v && ks_rdy[g]) begin
          total++;
          if (sb_vin[g] !== 1'b1 || sb_din[g] !== {{(DW-KW){1'b0}}, ks_d}) begin
            bad++; $display("FAIL ks_issue dut%0d got=%b/%h want=1/%h", g, sb_vin[g], sb_din[g], ks_d);
          end
          q.push_back('{own: 1'b1, data: sub_word({{(DW-KW){1'b0}}, ks_d}), due: cyc + 2});
        end
        if (st_rv[g] || ks_rv[g]) begin
          total++;
          if (st_rv[g]) st_cnt++;
          if (ks_rv[g]) ks_cnt++;
          if (q.size() == 0) begin
            bad++; $display("FAIL unexpected_rsp dut%0d cyc=%0d st=%b ks=%b want none", g, cyc, st_rv[g], ks_rv[g]);
          end else begin
            e = q.pop_front();
            if (e.due != cyc || (st_rv[g] && ks_rv[g]) || st_rv[g] !== !e.own ||
                (!e.own && st_rd[g] !== e.data) || (e.own && ks_rd[g] !== e.data[KW-1:0])) begin
              bad++;
              $display("FAIL rsp dut%0d cyc=%0d got st=%b ks=%b st_d=%h ks_d=%h want own=%0d due=%0d data=%h",
                       g, cyc, st_rv[g], ks_rv[g], st_rd[g], ks_rd[g], e.own, e.due, e.data);
            end
          end
        end
        if (q.size() > 0 && q[0].due < cyc) begin
          total++; bad++;
          $display("FAIL missing_rsp dut%0d due=%0d now=%0d", g, q[0].due, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    st_v = 0; ks_v = 0; inj = 0;
    rst = 0;
    repeat (2) tick();
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) tick();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({st_rdy[g], ks_rdy[g], sb_vin[g], st_rv[g], ks_rv[g], err[g], sb_din[g], st_rd[g], ks_rd[g]} !== '0) begin
        bad++; $display("FAIL reset_outputs dut%0d got nonzero want all 0", g);
      end
    end
    rst = 1;
    tick();
  endtask

  task automatic test_st_only();
    st_v = 1; st_d = '0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (st_rdy[g] !== 1'b1 || ks_rdy[g] !== 1'b0) begin
        bad++; $display("FAIL st_only_ready dut%0d got=%b%b want=10", g, st_rdy[g], ks_rdy[g]);
      end
    end
    tick(); st_v = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (st_rv[g] !== 1'b0) begin bad++; $display("FAIL st_only_early dut%0d got=1 want=0", g); end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (st_rv[g] !== 1'b1 || ks_rv[g] !== 1'b0 || st_rd[g] !== {16{8'h63}}) begin
        bad++; $display("FAIL st_only_rsp dut%0d got=%b%b %h want=10 %h", g, st_rv[g], ks_rv[g], st_rd[g], {16{8'h63}});
      end
    end
    tick();
  endtask

  task automatic test_ks_only();
    ks_v = 1; ks_d = 32'hcf4f3c09;
    tick(); ks_v = 0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if (ks_rv[g] !== 1'b1 || st_rv[g] !== 1'b0 || ks_rd[g] !== 32'h8a84eb01) begin
        bad++; $display("FAIL ks_only_rsp dut%0d got=%b%b %h want=10 8a84eb01", g, ks_rv[g], st_rv[g], ks_rd[g]);
      end
      total++;
      if (st_rd[g] !== {16{8'h63}}) begin
        bad++; $display("FAIL st_data_hold dut%0d got=%h want=%h", g, st_rd[g], {16{8'h63}});
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    int s0, k0, s1, k1;
    do_reset();
    s0 = g_dut[0].st_cnt; k0 = g_dut[0].ks_cnt; s1 = g_dut[1].st_cnt; k1 = g_dut[1].ks_cnt;
    st_v = 1; ks_v = 1;
    for (int i = 0; i < 8; i++) begin
      st_d = {$urandom, $urandom, $urandom, $urandom};
      ks_d = $urandom;
      @(negedge clk);
      total++;
      if (st_rdy[0] !== (i % 2 == 0) || ks_rdy[0] !== (i % 2 == 1)) begin
        bad++; $display("FAIL rr_grant i=%0d got=%b%b want=%b%b", i, st_rdy[0], ks_rdy[0], i % 2 == 0, i % 2 == 1);
      end
      tick();
    end
    st_v = 0; ks_v = 0;
    repeat (3) tick();
    total++;
    if (g_dut[0].st_cnt - s0 != 4 || g_dut[0].ks_cnt - k0 != 4) begin
      bad++; $display("FAIL rr_counts got st=%0d ks=%0d want 4/4", g_dut[0].st_cnt - s0, g_dut[0].ks_cnt - k0);
    end
    total++;
    if (g_dut[1].st_cnt - s1 != 8 || g_dut[1].ks_cnt - k1 != 0) begin
      bad++; $display("FAIL fixed_counts_rr got st=%0d ks=%0d want 8/0", g_dut[1].st_cnt - s1, g_dut[1].ks_cnt - k1);
    end
  endtask

  task automatic test_priority();
    int s1;
    s1 = g_dut[1].st_cnt;
    st_v = 1; ks_v = 1;
    for (int i = 0; i < 6; i++) begin
      st_d = {$urandom, $urandom, $urandom, $urandom};
      ks_d = $urandom;
      @(negedge clk);
      total++;
      if (st_rdy[1] !== 1'b1 || ks_rdy[1] !== 1'b0) begin
        bad++; $display("FAIL prio_grant i=%0d got=%b%b want=10", i, st_rdy[1], ks_rdy[1]);
      end
      tick();
    end
    st_v = 0; ks_v = 0;
    repeat (3) tick();
    total++;
    if (g_dut[1].st_cnt - s1 != 6) begin
      bad++; $display("FAIL prio_count got=%0d want=6", g_dut[1].st_cnt - s1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    st_v = 1; st_d = {4{32'h01234567}};
    tick();
    st_v = 0; rst = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (st_rv !== 2'b00) begin bad++; $display("FAIL mid_reset_pulse got=%b want=00", st_rv); end
      tick();
    end
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (st_rv !== 2'b00 || err !== 2'b00) begin
        bad++; $display("FAIL post_reset got st=%b err=%b want 00/00", st_rv, err);
      end
      tick();
    end
    st_v = 1; ks_v = 1;
    @(negedge clk);
    total++;
    if (st_rdy !== 2'b11 || ks_rdy !== 2'b00) begin
      bad++; $display("FAIL post_reset_contention got st=%b ks=%b want 11/00", st_rdy, ks_rdy);
    end
    tick();
    st_v = 0; ks_v = 0;
    repeat (3) tick();
  endtask

  task automatic test_err();
    do_reset();
    inj = 1;
    @(negedge clk);
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL err_early got=%b want=00", err); end
    tick(); inj = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (err !== 2'b11 || st_rv !== 2'b00 || ks_rv !== 2'b00) begin
        bad++; $display("FAIL err_sticky i=%0d got err=%b st=%b ks=%b want 11/00/00", i, err, st_rv, ks_rv);
      end
      tick();
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (err !== 2'b00) begin bad++; $display("FAIL err_clear got=%b want=00", err); end
    tick(); rst = 1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_st_only();
    test_ks_only();
    test_round_robin();
    test_priority();
    test_reset_mid();
    test_err();
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      total++;
      if (g == 0 ? g_dut[0].q.size() != 0 : g_dut[1].q.size() != 0) begin
        bad++; $display("FAIL drain dut%0d outstanding responses left, want none", g);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
